// File: rtl/countdown_59_timer.sv
// -----------------------------------------------------------------------------
// countdown_59_timer
//
// Seconds countdown timer. A preset of 00-59 s is loaded and then counted down
// to 00 at one step per second. The count is shown on two active-low
// 7-segment digits, and completion is flagged.
//
// The block contains a prescaler (one tick every TICK_DIV clocks), a two-digit
// BCD down-counter, a four-state control FSM (IDLE/RUN/PAUSE/DONE) and two
// segment decoders.
//
// Ports:
//   clock_sig    in   1  board clock, rising-edge active
//   reset_sig    in   1  asynchronous, active-low reset
//   start_sig    in   1  start/pause button (already synchronised); rising edge acts
//   load_sig     in   1  level; loads the clamped preset when not running
//   preset_tens  in   3  preset tens digit, clamped to 5
//   preset_ones  in   4  preset ones digit, clamped to 9
//   hex0         out  7  ones digit, active-low, bit0=a .. bit6=g
//   hex1         out  7  tens digit, same encoding
//   running_sig  out  1  high in RUN
//   done_sig     out  1  high in DONE
// -----------------------------------------------------------------------------
module countdown_59_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PRE_W    = 26
) (
    input  logic       clock_sig,
    input  logic       reset_sig,
    input  logic       start_sig,
    input  logic       load_sig,
    input  logic [2:0] preset_tens,
    input  logic [3:0] preset_ones,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic       running_sig,
    output logic       done_sig
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // Registered state
    logic [1:0]       state_reg,       state_next;
    logic [2:0]       tens_reg,        tens_next;
    logic [3:0]       ones_reg,        ones_next;
    logic [2:0]       latch_tens_reg,  latch_tens_next;
    logic [3:0]       latch_ones_reg,  latch_ones_next;
    logic [PRE_W-1:0] pre_reg,         pre_next;
    logic             start_q_reg;

    // Derived controls
    logic       start_rise;
    logic       load_ok;
    logic       tick;
    logic       count_zero;
    logic       dec_to_zero;
    logic [2:0] clamp_tens;
    logic [3:0] clamp_ones;

    assign start_rise  = start_sig & ~start_q_reg;
    assign load_ok     = load_sig && (state_reg != ST_RUN);
    assign tick        = (state_reg == ST_RUN) && (pre_reg == PRE_LAST);
    assign count_zero  = (tens_reg == 3'd0) && (ones_reg == 4'd0);
    // The decrement from 01 is the only one that lands on 00.
    assign dec_to_zero = (tens_reg == 3'd0) && (ones_reg == 4'd1);
    assign clamp_tens  = (preset_tens > 3'd5) ? 3'd5 : preset_tens;
    assign clamp_ones  = (preset_ones > 4'd9) ? 4'd9 : preset_ones;

    always_comb begin
        state_next      = state_reg;
        tens_next       = tens_reg;
        ones_next       = ones_reg;
        latch_tens_next = latch_tens_reg;
        latch_ones_next = latch_ones_reg;
        pre_next        = pre_reg;

        if (load_ok) begin
            // Load beats a simultaneous start edge.
            tens_next       = clamp_tens;
            ones_next       = clamp_ones;
            latch_tens_next = clamp_tens;
            latch_ones_next = clamp_ones;
            state_next      = ST_IDLE;
            pre_next        = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_rise) begin
                        if (count_zero) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_RUN;
                            pre_next   = '0;
                        end
                    end
                end
                ST_RUN: begin
                    // The cycle in which a pause arrives is still a running
                    // cycle, so the prescaler advances before being held. This
                    // keeps every second exactly TICK_DIV running cycles long.
                    if (tick) begin
                        pre_next = '0;
                        if (!count_zero) begin
                            if (ones_reg == 4'd0) begin
                                ones_next = 4'd9;
                                tens_next = tens_reg - 3'd1;
                            end else begin
                                ones_next = ones_reg - 4'd1;
                            end
                        end
                        if (dec_to_zero || count_zero) begin
                            state_next = ST_DONE;
                        end else if (start_rise) begin
                            state_next = ST_PAUSE;
                        end
                    end else begin
                        pre_next = pre_reg + 1'b1;
                        if (start_rise) begin
                            state_next = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_rise) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin // ST_DONE
                    if (start_rise) begin
                        state_next = ST_IDLE;
                        tens_next  = latch_tens_reg;
                        ones_next  = latch_ones_reg;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            state_reg      <= ST_IDLE;
            tens_reg       <= '0;
            ones_reg       <= '0;
            latch_tens_reg <= '0;
            latch_ones_reg <= '0;
            pre_reg        <= '0;
            start_q_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tens_reg       <= tens_next;
            ones_reg       <= ones_next;
            latch_tens_reg <= latch_tens_next;
            latch_ones_reg <= latch_ones_next;
            pre_reg        <= pre_next;
            start_q_reg    <= start_sig;
        end
    end

    // Segment decode, active-low, bit0=a .. bit6=g. Non-BCD codes blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [3:0] digit_val [2];
    logic [6:0] digit_seg [2];

    assign digit_val[0] = ones_reg;
    assign digit_val[1] = {1'b0, tens_reg};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            assign digit_seg[gi] = seg7(digit_val[gi]);
        end
    endgenerate

    assign hex0        = digit_seg[0];
    assign hex1        = digit_seg[1];
    assign running_sig = (state_reg == ST_RUN);
    assign done_sig    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_countdown_59_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_59_timer
//
// Directed scenarios followed by a randomized run. A reference model tracks the
// remaining time as a plain integer number of seconds plus the number of
// running cycles spent in the current second; expected displays are derived
// from that integer with /10 and %10.
// -----------------------------------------------------------------------------
module tb_countdown_59_timer;

    localparam int TICK = 4;

    logic       clock_sig;
    logic       reset_sig;
    logic       start_sig;
    logic       load_sig;
    logic [2:0] preset_tens;
    logic [3:0] preset_ones;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic       running_sig;
    logic       done_sig;

    countdown_59_timer #(
        .TICK_DIV (TICK),
        .PRE_W    (3)
    ) dut (
        .clock_sig   (clock_sig),
        .reset_sig   (reset_sig),
        .start_sig   (start_sig),
        .load_sig    (load_sig),
        .preset_tens (preset_tens),
        .preset_ones (preset_ones),
        .hex0        (hex0),
        .hex1        (hex1),
        .running_sig (running_sig),
        .done_sig    (done_sig)
    );

    initial clock_sig = 1'b0;
    always #5 clock_sig = ~clock_sig;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: 0 idle, 1 run, 2 pause, 3 done
    int m_state;
    int m_secs;
    int m_preset;
    int m_phase;
    bit m_start_q;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model_reset();
        m_state   = 0;
        m_secs    = 0;
        m_preset  = 0;
        m_phase   = 0;
        m_start_q = 1'b0;
    endtask

    // One clock edge of the model, using the inputs present before the edge.
    task automatic model_step();
        bit rise;
        int t;
        int o;
        rise      = start_sig && !m_start_q;
        m_start_q = start_sig;
        if (load_sig && m_state != 1) begin
            t        = (int'(preset_tens) > 5) ? 5 : int'(preset_tens);
            o        = (int'(preset_ones) > 9) ? 9 : int'(preset_ones);
            m_secs   = t * 10 + o;
            m_preset = m_secs;
            m_state  = 0;
            m_phase  = 0;
        end else begin
            case (m_state)
                0: if (rise) begin
                    if (m_secs > 0) begin
                        m_state = 1;
                        m_phase = 0;
                    end else begin
                        m_state = 3;
                    end
                end
                1: begin
                    m_phase++;
                    if (m_phase == TICK) begin
                        m_phase = 0;
                        m_secs--;
                        if (m_secs == 0) m_state = 3;
                        else if (rise)   m_state = 2;
                    end else if (rise) begin
                        m_state = 2;
                    end
                end
                2: if (rise) m_state = 1;
                default: if (rise) begin
                    m_state = 0;
                    m_secs  = m_preset;
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".hex0"}, hex0, seg_of(m_secs % 10));
        chk({tag, ".hex1"}, hex1, seg_of(m_secs / 10));
        chk({tag, ".run"}, {6'd0, running_sig}, {6'd0, (m_state == 1)});
        chk({tag, ".done"}, {6'd0, done_sig}, {6'd0, (m_state == 3)});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".hex0"}, hex0, 7'b1000000);
        chk({tag, ".hex1"}, hex1, 7'b1000000);
        chk({tag, ".run"}, {6'd0, running_sig}, 7'd0);
        chk({tag, ".done"}, {6'd0, done_sig}, 7'd0);
    endtask

    // Advance one clock, step the model, sample 1 time unit after the edge.
    task automatic step(input string tag);
        @(posedge clock_sig);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic start_pulse(input string tag);
        start_sig = 1'b1;
        step(tag);
        start_sig = 1'b0;
    endtask

    task automatic load_preset(input string tag, input logic [2:0] t, input logic [3:0] o);
        preset_tens = t;
        preset_ones = o;
        load_sig    = 1'b1;
        step(tag);
        load_sig    = 1'b0;
    endtask

    initial begin
        reset_sig   = 1'b0;
        start_sig   = 1'b0;
        load_sig    = 1'b0;
        preset_tens = 3'd0;
        preset_ones = 4'd0;
        model_reset();

        // 1. Reset values, then release between edges
        repeat (2) @(posedge clock_sig);
        #1;
        check_reset_vals("rst_hold");
        @(posedge clock_sig);
        #3;
        reset_sig = 1'b1;
        #1;
        check_reset_vals("rst_release");
        steps("post_rst", 3);
        $display("txn reset: done");

        // 2. Preset 12, countdown to DONE
        load_preset("t2_load", 3'd1, 4'd2);
        chk("t2_12.hex0", hex0, seg_of(2));
        start_pulse("t2_start");
        steps("t2_run", 4);
        chk("t2_11.hex0", hex0, seg_of(1));
        chk("t2_11.hex1", hex1, seg_of(1));
        steps("t2_run", 4);
        chk("t2_10.hex0", hex0, seg_of(0));
        steps("t2_run", 4);
        chk("t2_09.hex0", hex0, seg_of(9));
        chk("t2_09.hex1", hex1, seg_of(0));
        steps("t2_run", 36);
        chk("t2_00.hex0", hex0, seg_of(0));
        chk("t2_00.hex1", hex1, seg_of(0));
        chk("t2_00.done", {6'd0, done_sig}, 7'd1);
        chk("t2_00.run", {6'd0, running_sig}, 7'd0);
        $display("txn countdown12: done=%0b", done_sig);

        // 3. Clamp 7/15 -> 59, pause/resume keeps prescaler phase
        load_preset("t3_load", 3'd7, 4'd15);
        chk("t3_59.hex1", hex1, seg_of(5));
        chk("t3_59.hex0", hex0, seg_of(9));
        start_pulse("t3_start");
        steps("t3_run", 4);
        chk("t3_58.hex0", hex0, seg_of(8));
        step("t3_run");
        start_pulse("t3_pause");
        chk("t3_pause.run", {6'd0, running_sig}, 7'd0);
        steps("t3_hold", 20);
        chk("t3_hold.hex0", hex0, seg_of(8));
        start_pulse("t3_resume");
        steps("t3_run", 2);
        chk("t3_57.hex0", hex0, seg_of(7));
        $display("txn pause_resume: hex0=%b", hex0);

        // 4. Load ignored in RUN; load+start in PAUSE -> IDLE with preset
        preset_tens = 3'd3;
        preset_ones = 4'd0;
        load_sig    = 1'b1;
        steps("t4_load_in_run", 3);
        load_sig    = 1'b0;
        chk("t4_ign.hex1", hex1, seg_of(5));
        start_pulse("t4_pause");
        step("t4_gap");
        start_sig = 1'b1;
        load_sig  = 1'b1;
        step("t4_load_start");
        start_sig = 1'b0;
        load_sig  = 1'b0;
        chk("t4_30.hex1", hex1, seg_of(3));
        chk("t4_30.hex0", hex0, seg_of(0));
        chk("t4_30.run", {6'd0, running_sig}, 7'd0);
        steps("t4_idle", 2);
        $display("txn load_priority: hex1=%b", hex1);

        // 5. Preset 00 -> DONE at once; DONE -> IDLE reload
        load_preset("t5_load0", 3'd0, 4'd0);
        start_pulse("t5_start0");
        chk("t5_done.done", {6'd0, done_sig}, 7'd1);
        step("t5_gap");
        start_pulse("t5_back");
        chk("t5_idle.done", {6'd0, done_sig}, 7'd0);
        load_preset("t5_load5", 3'd0, 4'd5);
        start_pulse("t5_start5");
        steps("t5_run", 20);
        chk("t5_end.done", {6'd0, done_sig}, 7'd1);
        step("t5_gap");
        start_pulse("t5_reload");
        chk("t5_reload.hex0", hex0, seg_of(5));
        chk("t5_reload.done", {6'd0, done_sig}, 7'd0);
        $display("txn done_reload: hex0=%b", hex0);

        // 6. Asynchronous reset mid-run at 33
        load_preset("t6_load", 3'd3, 4'd5);
        start_pulse("t6_start");
        steps("t6_run", 8);
        chk("t6_33.hex0", hex0, seg_of(3));
        #2;
        reset_sig = 1'b0;
        #1;
        model_reset();
        check_reset_vals("t6_async");
        @(posedge clock_sig);
        #3;
        reset_sig = 1'b1;
        steps("t6_after", 10);
        $display("txn async_reset: hex0=%b run=%0b", hex0, running_sig);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) start_sig = ~start_sig;
            load_sig    = ($urandom_range(0, 19) == 0);
            preset_tens = 3'($urandom_range(0, 7));
            preset_ones = 4'($urandom_range(0, 15));
            step("rand");
        end
        start_sig = 1'b0;
        load_sig  = 1'b0;
        $display("txn random: 400 cycles");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/countdown_59_timer.md
Name:
countdown_59_timer

Overview:
- Seconds countdown timer, complement to the 0-to-59 up-counter: loads a preset of 00-59 s and counts down to 00 at 1 Hz.
- Shows tens/ones on two active-low 7-segment digits and flags completion.
- Sits beside the up-counter on the DE-board top level and shares the board clock and reset button.
- Contains its own prescaler, two-digit BCD down-counter, control FSM and segment decoders.

Parameters:
TICK_DIV, 50_000_000, clock cycles per one-second tick; the bench overrides it to 4; legal range is 2 or more.
PRE_W, 26, prescaler width; must satisfy 2^PRE_W >= TICK_DIV.

Ports:
clock_sig  input  1  board clock; all state changes on its rising edge
reset_sig  input  1  asynchronous, active-low reset
start_sig  input  1  start/pause control, already synchronised; only its rising edge acts
load_sig  input  1  synchronous level; loads the preset when sampled high
preset_tens  input  3  tens digit of the preset; values above 5 are clamped to 5
preset_ones  input  4  ones digit of the preset; values above 9 are clamped to 9
hex0  output  7  ones digit, active-low segments, bit0=a through bit6=g
hex1  output  7  tens digit, same encoding as hex0
running_sig  output  1  high while in state RUN
done_sig  output  1  high while in state DONE

Behaviour:
Reset (reset_sig=0, asynchronous):
- state=IDLE; tens=0, ones=0; preset latch=00; prescaler=0; start edge register=0.
- Outputs during and after reset: hex0=hex1=7'b1000000 (shows "0"), running_sig=0, done_sig=0.
- Reset asserted mid-count aborts the run immediately with no further ticks.

Start edge detection:
- start_rise = start_sig & ~start_q, where start_q is start_sig registered.
- Holding start_sig high produces one event only.

Load:
- Acts only in IDLE, PAUSE and DONE; ignored in RUN.
- Clamped preset goes into both the count register and the preset latch; state becomes IDLE; prescaler=0.
- Load and start_rise in the same cycle: load wins and start_rise is discarded.

FSM:
- IDLE: start_rise with count!=00 -> RUN, prescaler=0. start_rise with count==00 -> DONE.
- RUN: prescaler increments each cycle. When prescaler==TICK_DIV-1: tick, prescaler=0.
  - start_rise (without a tick) -> PAUSE; the prescaler value is held.
- PAUSE: count and prescaler frozen. start_rise -> RUN, resuming from the held prescaler value, so no time is lost.
- DONE: count stays at 00. start_rise -> IDLE with the count reloaded from the preset latch.

Tick decrement (BCD):
- ones>0: ones-1.
- ones==0: ones=9, tens-1.
- If the tick makes the count 00, the same edge moves the state RUN -> DONE. done_sig is high in the following cycle and running_sig is low in that cycle.
- start_rise in the same cycle as a tick: the decrement is applied first, then RUN -> PAUSE. If that decrement reaches 00, the state goes to DONE instead.
- Underflow below 00 is impossible; no wrap to 59.

Latency and display:
- A preset loaded in IDLE at 59 produces the first decrement exactly TICK_DIV cycles after the RUN transition edge.
- hex0 and hex1 are combinational decodes of the count registers, valid in the same cycle as the count.
- Segment values: digit 0-9 use standard active-low codes. Codes 10-15 cannot occur; the decoder drives blank (7'b1111111) for them.
- running_sig and done_sig are decoded directly from the registered state; no glitch requirement beyond that.

Test Plan:
1. Reset with TICK_DIV=4 -> hex0=hex1=7'b1000000, running_sig=0, done_sig=0; reset released mid-cycle -> no output change.
2. Load preset 1/2 (12), then one start pulse.
   - hex shows 12, then 11 four cycles after RUN entry, 10 after 8 cycles, 09 after 12 cycles (ones wraps to 9, tens decrements).
   - 00 after 48 cycles; done_sig=1 and running_sig=0 on the next cycle.
3. Preset 7/15 -> count clamps to 59. Start, pause after 6 cycles, hold 20 cycles, resume.
   - 58 appears at cycle 4 of RUN; 57 appears 2 RUN-cycles after resume; no change during PAUSE.
4. In RUN, toggle load_sig with preset 30 -> ignored, countdown continues.
   - Pause, then assert load and start_rise in the same cycle -> count=30, state IDLE, running_sig=0.
5. Preset 00 plus start -> DONE immediately, done_sig=1. Start again -> IDLE, count=00.
   - Preset 05, run to 00, then start in DONE -> count reloads to 05 in IDLE.
6. Assert reset_sig=0 asynchronously between edges at count 33 in RUN -> immediate return to all reset values; no tick after release until the next start.
